// File: rtl/exe_unit_w1_pkg.sv
// Shared constants for the w1 execution unit: opcode encodings and status bit positions.
package exe_unit_w1_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  localparam int ST_ZERO = 0;
  localparam int ST_NEG  = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_ERR  = 3;

endpackage

// File: rtl/exe_unit_w1_alu.sv
// Combinational core of the execution unit: computes next result and status flags
// from two signed operands and the low two opcode bits.
module exe_unit_w1_alu
  import exe_unit_w1_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic [n-1:0] oper_i,
  input  logic [m-1:0] arg_a_i,
  input  logic [m-1:0] arg_b_i,
  output logic [m-1:0] result_o,
  output logic [3:0]   status_o
);

  localparam logic [m:0] M_EXT = (m+1)'(m);

  logic [m-1:0] sum;
  logic [m-1:0] diff;
  logic [m-1:0] asr;
  logic         ovf;
  logic         err;

  assign sum  = arg_a_i + arg_b_i;
  assign diff = arg_a_i - arg_b_i;
  assign asr  = $signed(arg_a_i) >>> arg_b_i;

  always_comb begin
    result_o = '0;
    ovf      = 1'b0;
    err      = 1'b0;
    case (oper_i[1:0])
      OP_ADD: begin
        result_o = sum;
        ovf      = (arg_a_i[m-1] == arg_b_i[m-1]) && (sum[m-1] != arg_a_i[m-1]);
      end
      OP_SUB: begin
        result_o = diff;
        ovf      = (arg_a_i[m-1] != arg_b_i[m-1]) && (diff[m-1] != arg_a_i[m-1]);
      end
      OP_AND: begin
        result_o = arg_a_i & arg_b_i;
      end
      default: begin
        // A negative shift amount is illegal: flag it and force a zero result.
        if (arg_b_i[m-1]) begin
          err = 1'b1;
        end else if ({1'b0, arg_b_i} >= M_EXT) begin
          result_o = {m{arg_a_i[m-1]}};
        end else begin
          result_o = asr;
        end
      end
    endcase
  end

  always_comb begin
    status_o          = '0;
    status_o[ST_ZERO] = (result_o == '0);
    status_o[ST_NEG]  = result_o[m-1];
    status_o[ST_OVF]  = ovf;
    status_o[ST_ERR]  = err;
  end

endmodule

// File: rtl/exe_unit_w1_core.sv
// Registered single-cycle execution stage. A new operation is accepted on every
// rising edge (no valid/ready); results appear one edge after their operands.
module exe_unit_w1_core
  import exe_unit_w1_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic [n-1:0] i_oper,
  input  logic [m-1:0] i_argA,
  input  logic [m-1:0] i_argB,
  output logic [m-1:0] o_result,
  output logic [3:0]   o_status
);

  logic [m-1:0] result_d;
  logic [m-1:0] result_q;
  logic [3:0]   status_d;
  logic [3:0]   status_q;

  exe_unit_w1_alu #(
    .m(m),
    .n(n)
  ) u_alu (
    .oper_i  (i_oper),
    .arg_a_i (i_argA),
    .arg_b_i (i_argB),
    .result_o(result_d),
    .status_o(status_d)
  );

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_result = result_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_exe_unit_w1_core.sv
// Bench for exe_unit_w1_core: directed vectors plus randomized operations checked
// through an expected-value queue against an integer reference model.
module tb_exe_unit_w1_core;

  localparam int M = 4;
  localparam int N = 3;
  localparam int W = M + 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] oper;
  logic [M-1:0] arg_a;
  logic [M-1:0] arg_b;
  logic [M-1:0] result;
  logic [3:0]   status;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  exe_unit_w1_core #(
    .m(M),
    .n(N)
  ) dut (
    .i_clk   (clk),
    .i_rsn   (rst_n),
    .i_oper  (oper),
    .i_argA  (arg_a),
    .i_argB  (arg_b),
    .o_result(result),
    .o_status(status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed integer arithmetic, then wrap to M bits.
  function automatic logic [W-1:0] model(input int op, input int a, input int b);
    int lo;
    int hi;
    int r;
    int d;
    logic ovf;
    logic err;
    logic [M-1:0] rb;
    lo  = -(1 << (M - 1));
    hi  = (1 << (M - 1)) - 1;
    r   = 0;
    ovf = 1'b0;
    err = 1'b0;
    case (op % 4)
      0: begin r = a + b; ovf = (r > hi) || (r < lo); end
      1: begin r = a - b; ovf = (r > hi) || (r < lo); end
      2: r = a & b;
      default: begin
        if (b < 0) begin
          r = 0; err = 1'b1;
        end else if (b >= M) begin
          r = (a < 0) ? -1 : 0;
        end else begin
          d = 1 << b;
          r = (a >= 0) ? a / d : -((-a + d - 1) / d);
        end
      end
    endcase
    rb = M'(r);
    return {err, ovf, rb[M-1], (rb == '0), rb};
  endfunction

  function automatic logic [W-1:0] model_bits(input logic [N-1:0] op, input logic [M-1:0] a,
                                              input logic [M-1:0] b);
    logic signed [M-1:0] sa;
    logic signed [M-1:0] sb;
    int ai;
    int bi;
    sa = a;
    sb = b;
    ai = sa;
    bi = sb;
    return model(int'(op), ai, bi);
  endfunction

  // driver tasks
  task automatic drive_now(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b,
                           input logic [W-1:0] exp);
    oper  = op;
    arg_a = a;
    arg_b = b;
    exp_q.push_back(exp);
  endtask

  task automatic do_op(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b,
                       input logic [W-1:0] exp);
    @(negedge clk);
    drive_now(op, a, b, exp);
  endtask

  task automatic do_rand();
    logic [N-1:0] op;
    logic [M-1:0] a;
    logic [M-1:0] b;
    op = N'($urandom_range(0, (1 << N) - 1));
    a  = M'($urandom);
    b  = M'($urandom);
    do_op(op, a, b, model_bits(op, a, b));
  endtask

  task automatic check_now(input string name, input logic [W-1:0] exp);
    checks++;
    if ({status, result} !== exp) begin
      failures++;
      $display("FAIL %s: got status=%b result=%b, want status=%b result=%b",
               name, status, result, exp[W-1:M], exp[M-1:0]);
    end
  endtask

  // scoreboard monitor: one expected entry per captured edge
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [W-1:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({status, result} !== exp) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got status=%b result=%b, want status=%b result=%b",
                 $time, status, result, exp[W-1:M], exp[M-1:0]);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    oper     = N'($urandom);
    arg_a    = M'($urandom);
    arg_b    = M'($urandom);

    #2;
    check_now("reset_before_clock", '0);
    repeat (3) begin
      @(posedge clk);
      #2;
      oper  = N'($urandom);
      arg_a = M'($urandom);
      arg_b = M'($urandom);
      check_now("reset_while_clocking", '0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive_now(3'b000, 4'b0011, 4'b0001, {4'b0000, 4'b0100});

    do_op(3'b011, 4'b1000, 4'b0001, {4'b0010, 4'b1100});
    do_op(3'b011, 4'b1001, 4'b0011, {4'b0010, 4'b1111});
    do_op(3'b011, 4'b0111, 4'b0011, {4'b0001, 4'b0000});
    do_op(3'b011, 4'b0110, 4'b0011, {4'b0001, 4'b0000});
    do_op(3'b011, 4'b0101, 4'b0011, {4'b0001, 4'b0000});
    do_op(3'b011, 4'b1000, 4'b0100, {4'b0010, 4'b1111});
    do_op(3'b011, 4'b0101, 4'b1111, {4'b1001, 4'b0000});
    do_op(3'b000, 4'b0111, 4'b0001, {4'b0110, 4'b1000});
    do_op(3'b001, 4'b1000, 4'b0001, {4'b0100, 4'b0111});
    do_op(3'b000, 4'b1000, 4'b1000, {4'b0101, 4'b0000});
    do_op(3'b111, 4'b1000, 4'b0001, {4'b0010, 4'b1100});
    do_op(3'b110, 4'b1010, 4'b0110, {4'b0000, 4'b0010});

    // inputs wiggle mid-cycle; registered outputs must not follow
    @(posedge clk);
    #2;
    oper  = 3'b000;
    arg_a = 4'b0111;
    arg_b = 4'b0111;
    #2;
    check_now("stable_between_edges", {4'b0000, 4'b0010});

    // reset between edges, with an operation already presented
    do_op(3'b000, 4'b0010, 4'b0010, {4'b0000, 4'b0100});
    @(posedge clk);
    #3;
    do_op(3'b001, 4'b0001, 4'b0011, {4'b0010, 4'b1110});
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_now("async_reset_midstream", '0);
    @(posedge clk);
    #2;
    check_now("reset_holds_over_edge", '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(3'b001, 4'b0001, 4'b0011, {4'b0010, 4'b1110});

    for (int i = 0; i < 300; i++) begin
      do_rand();
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
